// File: rtl/clkmon_pkg.sv
// Shared definitions for the clock-monitor family: FSM states and synchronizer sizing.
package clkmon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StArm,
    StRun
  } clkmon_state_e;

  // Cycles spent flushing the synchronizer before a window starts.
  localparam int unsigned ARM_CYCLES = 3;
  localparam int unsigned SYNC_DEPTH = 3;

endpackage

// File: rtl/clkmon_sync_edge.sv
// Synchronizes an asynchronous clock into the local domain and flags its rising edges.
module clkmon_sync_edge
  import clkmon_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  // sync_q[0] is the metastability-catching flop; the top two form the edge detector.
  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], async_in};
    end
  end

  assign rise = sync_q[SYNC_DEPTH-2] & ~sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/clkmon_freq_check.sv
// Counts monitored-clock rising edges per fixed reference window and raises sticky
// under-frequency, over-frequency and stuck-clock flags.
module clkmon_freq_check
  import clkmon_pkg::*;
#(
  parameter int unsigned WIN_LEN   = 64,
  parameter int unsigned CNT_W     = 7,
  parameter int unsigned STUCK_LIM = 16
) (
  input  logic             CLK,
  input  logic             RN,
  inout  wire              VDD,
  inout  wire              VSS,
  input  logic             MCLK,
  input  logic             EN,
  input  logic             CLR,
  input  logic [CNT_W-1:0] LO_TH,
  input  logic [CNT_W-1:0] HI_TH,
  output logic [CNT_W-1:0] CNT,
  output logic             VALID,
  output logic             LOW_ERR,
  output logic             HIGH_ERR,
  output logic             STUCK
);

  localparam int unsigned WinW   = $clog2(WIN_LEN);
  localparam int unsigned StuckW = $clog2(STUCK_LIM + 1);
  localparam int unsigned ArmW   = $clog2(ARM_CYCLES);

  localparam logic [WinW-1:0]   WinLast  = WinW'(WIN_LEN - 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_LIM);
  localparam logic [ArmW-1:0]   ArmLast  = ArmW'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  EdgeMax  = '1;

  clkmon_state_e     state_q, state_d;
  logic [ArmW-1:0]   arm_q, arm_d;
  logic [WinW-1:0]   win_q, win_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              low_q, high_q, stuck_q;
  logic              low_set, high_set, stuck_set;
  logic [CNT_W-1:0]  edge_next;
  logic              rise;

  clkmon_sync_edge u_sync (
    .clk      (CLK),
    .rst_n    (RN),
    .async_in (MCLK),
    .rise     (rise)
  );

  // The edge seen on the last cycle of a window still belongs to that window.
  assign edge_next = (rise && (edge_q != EdgeMax)) ? edge_q + CNT_W'(1) : edge_q;

  always_comb begin
    state_d     = state_q;
    arm_d       = arm_q;
    win_d       = win_q;
    edge_d      = edge_q;
    stuck_cnt_d = stuck_cnt_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    low_set     = 1'b0;
    high_set    = 1'b0;
    stuck_set   = 1'b0;

    case (state_q)
      StIdle: begin
        arm_d       = '0;
        win_d       = '0;
        edge_d      = '0;
        stuck_cnt_d = '0;
        state_d     = StArm;
      end
      StArm: begin
        if (arm_q == ArmLast) begin
          state_d     = StRun;
          arm_d       = '0;
          win_d       = '0;
          edge_d      = '0;
          stuck_cnt_d = '0;
        end else begin
          arm_d = arm_q + ArmW'(1);
        end
      end
      StRun: begin
        if (win_q == WinLast) begin
          cnt_d    = edge_next;
          valid_d  = 1'b1;
          low_set  = (edge_next < LO_TH);
          high_set = (edge_next > HI_TH);
          win_d    = '0;
          edge_d   = '0;
        end else begin
          win_d  = win_q + WinW'(1);
          edge_d = edge_next;
        end
        if (rise) begin
          stuck_cnt_d = '0;
        end else if (stuck_cnt_q != StuckMax) begin
          stuck_cnt_d = stuck_cnt_q + StuckW'(1);
        end
        stuck_set = (stuck_cnt_d == StuckMax);
      end
      default: state_d = StIdle;
    endcase

    // Disabling aborts whatever is in flight; results and flags are left alone.
    if (!EN) begin
      state_d     = StIdle;
      arm_d       = '0;
      win_d       = '0;
      edge_d      = '0;
      stuck_cnt_d = '0;
      cnt_d       = cnt_q;
      valid_d     = 1'b0;
      low_set     = 1'b0;
      high_set    = 1'b0;
      stuck_set   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q     <= StIdle;
      arm_q       <= '0;
      win_q       <= '0;
      edge_q      <= '0;
      stuck_cnt_q <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      low_q       <= 1'b0;
      high_q      <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      arm_q       <= arm_d;
      win_q       <= win_d;
      edge_q      <= edge_d;
      stuck_cnt_q <= stuck_cnt_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      // A set in the same cycle as CLR takes priority.
      low_q       <= low_set | (low_q & ~CLR);
      high_q      <= high_set | (high_q & ~CLR);
      stuck_q     <= stuck_set | (stuck_q & ~CLR);
    end
  end

  assign CNT      = cnt_q;
  assign VALID    = valid_q;
  assign LOW_ERR  = low_q;
  assign HIGH_ERR = high_q;
  assign STUCK    = stuck_q;

endmodule

// File: tb/tb_clkmon_freq_check.sv
// Directed bench for clkmon_freq_check: table of steady-state frequency cases plus
// hand-written sequences for clear priority, stuck detection, disable and reset.
module tb_clkmon_freq_check;

  logic       CLK = 1'b0;
  logic       RN = 1'b0;
  logic       MCLK = 1'b0;
  logic       EN = 1'b0;
  logic       CLR = 1'b0;
  logic [6:0] LO_TH = '0;
  logic [6:0] HI_TH = '0;
  logic [6:0] CNT;
  logic       VALID, LOW_ERR, HIGH_ERR, STUCK;
  wire        VDD, VSS;

  assign VDD = 1'b1;
  assign VSS = 1'b0;

  int checks = 0;
  int failures = 0;

  // MCLK source: divide-by-mdiv of CLK, or the level in mclk_man when mdiv is 0.
  int   mdiv = 0;
  int   mph = 0;
  logic mclk_man = 1'b0;

  clkmon_freq_check #(
    .WIN_LEN   (64),
    .CNT_W     (7),
    .STUCK_LIM (16)
  ) dut (
    .CLK      (CLK),
    .RN       (RN),
    .VDD      (VDD),
    .VSS      (VSS),
    .MCLK     (MCLK),
    .EN       (EN),
    .CLR      (CLR),
    .LO_TH    (LO_TH),
    .HI_TH    (HI_TH),
    .CNT      (CNT),
    .VALID    (VALID),
    .LOW_ERR  (LOW_ERR),
    .HIGH_ERR (HIGH_ERR),
    .STUCK    (STUCK)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mdiv == 0) begin
      MCLK = mclk_man;
      mph  = 0;
    end else begin
      mph = mph + 1;
      if (mph >= mdiv / 2) begin
        mph  = 0;
        MCLK = ~MCLK;
      end
    end
  end

  typedef struct {
    int         div;
    logic [6:0] lo;
    logic [6:0] hi;
    int         exp_cnt;
    int         exp_low;
    int         exp_high;
    int         exp_stuck;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!VALID && n < 200);
    if (!VALID) begin
      checks++;
      failures++;
      $display("FAIL valid_timeout: got no VALID in %0d cycles expected one", n);
    end
  endtask

  task automatic reset_dut();
    EN  = 1'b0;
    CLR = 1'b0;
    RN  = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RN = 1'b1;
  endtask

  task automatic start(input int div, input logic [6:0] lo, input logic [6:0] hi);
    reset_dut();
    mdiv  = div;
    LO_TH = lo;
    HI_TH = hi;
    EN    = 1'b1;
  endtask

  initial begin
    int n;

    //          div lo  hi  cnt low high stuck
    vecs[0] = '{4,  14, 18, 16, 0,  0,   0};
    vecs[1] = '{8,  14, 18, 8,  1,  0,   0};
    vecs[2] = '{4,  14, 10, 16, 0,  1,   0};
    vecs[3] = '{4,  20, 10, 16, 1,  1,   0};
    vecs[4] = '{16, 2,  6,  4,  0,  0,   0};
    vecs[5] = '{32, 3,  5,  2,  1,  0,   1};

    // Reset state
    reset_dut();
    chk("reset_cnt", int'(CNT), 0);
    chk("reset_valid", int'(VALID), 0);
    chk("reset_flags", int'({LOW_ERR, HIGH_ERR, STUCK}), 0);

    // Steady-state windows: second window is exact for every divider used.
    for (int i = 0; i < 6; i++) begin
      start(vecs[i].div, vecs[i].lo, vecs[i].hi);
      wait_valid(n);
      chk($sformatf("v%0d_first_latency", i), n, 68);
      wait_valid(n);
      chk($sformatf("v%0d_period", i), n, 64);
      chk($sformatf("v%0d_cnt", i), int'(CNT), vecs[i].exp_cnt);
      chk($sformatf("v%0d_low", i), int'(LOW_ERR), vecs[i].exp_low);
      chk($sformatf("v%0d_high", i), int'(HIGH_ERR), vecs[i].exp_high);
      chk($sformatf("v%0d_stuck", i), int'(STUCK), vecs[i].exp_stuck);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_valid_pulse", i), int'(VALID), 0);
    end

    // CLR after an under-frequency window; flag stays clear at the correct rate.
    start(8, 14, 18);
    wait_valid(n);
    wait_valid(n);
    chk("clr_low_before", int'(LOW_ERR), 1);
    mdiv = 4;
    wait_valid(n);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("clr_low_cleared", int'(LOW_ERR), 0);
    wait_valid(n);
    chk("clr_cnt_after", int'(CNT), 16);
    chk("clr_low_stays", int'(LOW_ERR), 0);

    // CLR coincident with a setting window end: set wins. CLR alone then clears.
    start(4, 14, 10);
    repeat (67) @(posedge CLK);
    #1;
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("setwins_valid", int'(VALID), 1);
    chk("setwins_high", int'(HIGH_ERR), 1);
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    chk("clr_high", int'(HIGH_ERR), 0);

    // Stuck: one isolated MCLK rise, then MCLK held low.
    start(4, 14, 18);
    wait_valid(n);
    @(posedge CLK);
    #1;
    mdiv     = 0;
    mclk_man = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    mclk_man = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    mclk_man = 1'b0;
    repeat (14) @(posedge CLK);
    #1;
    chk("stuck_not_yet", int'(STUCK), 0);
    @(posedge CLK);
    #1;
    chk("stuck_set", int'(STUCK), 1);
    wait_valid(n);
    chk("stuck_cnt_low", int'(CNT < 7'd16), 1);
    chk("stuck_low_err", int'(LOW_ERR), 1);
    chk("stuck_held", int'(STUCK), 1);

    // EN dropped at win_cnt=30 for 5 cycles: aborted window, results held.
    start(4, 14, 18);
    wait_valid(n);
    wait_valid(n);
    repeat (30) @(posedge CLK);
    #1;
    EN = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK);
      #1;
      chk($sformatf("dis_valid_%0d", c), int'(VALID), 0);
      chk($sformatf("dis_cnt_%0d", c), int'(CNT), 16);
      chk($sformatf("dis_flags_%0d", c), int'({LOW_ERR, HIGH_ERR, STUCK}), 0);
    end
    EN = 1'b1;
    wait_valid(n);
    chk("reen_latency", n, 68);
    chk("reen_flags", int'({LOW_ERR, HIGH_ERR}), 0);

    // Reset mid-window with flags set, then restart through ARM.
    start(4, 20, 10);
    wait_valid(n);
    chk("rst_pre_flags", int'({LOW_ERR, HIGH_ERR}), 3);
    repeat (20) @(posedge CLK);
    #1;
    RN = 1'b0;
    @(posedge CLK);
    #1;
    RN = 1'b1;
    chk("rst_mid_cnt", int'(CNT), 0);
    chk("rst_mid_flags", int'({LOW_ERR, HIGH_ERR, STUCK}), 0);
    chk("rst_mid_valid", int'(VALID), 0);
    wait_valid(n);
    chk("rst_restart_latency", n, 68);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
